// File: rtl/oc8051_shmem_resp.sv
// Shared-memory responder: 256x8 store behind a one-byte address window, with wait states.
// Optional supervisor-region protection is built when OC8051_SHMEM_PROT_EN is defined.
module oc8051_shmem_resp #(
  parameter logic [7:0] BASE_HI     = 8'hF0,
  parameter int         WAIT_CYCLES = 1,
  parameter logic [7:0] PROT_LIMIT  = 8'h80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic        priv_lvl,
  input  logic [15:0] dpc_ot,
  input  logic        selected_proc,
  output logic        ack,
  output logic [7:0]  data_out,
  output logic        viol,
  output logic [15:0] viol_addr,
  output logic [15:0] viol_pc,
  output logic        viol_proc,
  output logic [7:0]  viol_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam bit         HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  off_q, data_q;
  logic        wr_q;
  logic [7:0]  mem [0:255];

  logic        hit, idle, accept, enter_ack, blocked, mem_we;
  logic [7:0]  cur_off, cur_data;
  logic        cur_wr;

  assign hit    = stb && (addr[15:8] == BASE_HI);
  assign idle   = (state_q == IDLE);
  assign accept = idle && hit;

  // With no wait states the access completes on the accepting edge, so use live inputs then.
  assign cur_off  = idle ? addr[7:0] : off_q;
  assign cur_wr   = idle ? wr        : wr_q;
  assign cur_data = idle ? data_in   : data_q;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          if (HAS_WAIT) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ACK;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_ack = (state_d == ACK);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      ack      <= 1'b0;
      data_out <= 8'h00;
      off_q    <= 8'h00;
      data_q   <= 8'h00;
      wr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack     <= enter_ack;
      if (accept) begin
        off_q  <= addr[7:0];
        data_q <= data_in;
        wr_q   <= wr;
      end
      if (enter_ack && !cur_wr)
        data_out <= blocked ? 8'h00 : mem[cur_off];
    end
  end

  assign mem_we = enter_ack && cur_wr && !blocked && !rst;

  // NOTE: the storage array has no reset; its contents survive rst by design.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_off] <= cur_data;
  end

`ifdef OC8051_SHMEM_PROT_EN
  logic        priv_q, proc_q;
  logic [15:0] pc_q;
  logic        cur_priv, cur_proc;
  logic [15:0] cur_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      priv_q <= 1'b0;
      proc_q <= 1'b0;
      pc_q   <= 16'h0000;
    end else if (accept) begin
      priv_q <= priv_lvl;
      proc_q <= selected_proc;
      pc_q   <= dpc_ot;
    end
  end

  assign cur_priv = idle ? priv_lvl      : priv_q;
  assign cur_proc = idle ? selected_proc : proc_q;
  assign cur_pc   = idle ? dpc_ot        : pc_q;
  assign blocked  = (cur_off >= PROT_LIMIT) && !cur_priv;

  // Upper address byte of an accepted request is always BASE_HI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viol      <= 1'b0;
      viol_addr <= 16'h0000;
      viol_pc   <= 16'h0000;
      viol_proc <= 1'b0;
      viol_cnt  <= 8'h00;
    end else begin
      viol <= enter_ack && blocked;
      if (enter_ack && blocked) begin
        viol_addr <= {BASE_HI, cur_off};
        viol_pc   <= cur_pc;
        viol_proc <= cur_proc;
        if (viol_cnt != 8'hFF) viol_cnt <= viol_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_prot;

  assign blocked     = 1'b0;
  assign viol        = 1'b0;
  assign viol_addr   = 16'h0000;
  assign viol_pc     = 16'h0000;
  assign viol_proc   = 1'b0;
  assign viol_cnt    = 8'h00;
  assign unused_prot = ^{priv_lvl, dpc_ot, selected_proc};
`endif

endmodule

// File: tb/tb_oc8051_shmem_resp.sv
// Randomized bench for oc8051_shmem_resp against a transaction-level model of the memory
// and violation log; also exercises a zero-wait-state instance.
module tb_oc8051_shmem_resp;

  localparam int WAIT = 1;
`ifdef OC8051_SHMEM_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk, rst, stb, wr, priv_lvl, selected_proc;
  logic [15:0] addr, dpc_ot;
  logic [7:0]  data_in;
  logic        ack, viol, viol_proc;
  logic [7:0]  data_out, viol_cnt;
  logic [15:0] viol_addr, viol_pc;

  logic        stb0, ack0, viol0;
  logic [15:0] addr0;
  logic [7:0]  data_out0;
  logic [15:0] w0_unused_vaddr, w0_unused_vpc;
  logic        w0_unused_vproc;
  logic [7:0]  w0_unused_vcnt;

  oc8051_shmem_resp #(.BASE_HI(8'hF0), .WAIT_CYCLES(WAIT), .PROT_LIMIT(8'h80)) dut (
    .clk(clk), .rst(rst), .stb(stb), .wr(wr), .addr(addr), .data_in(data_in),
    .priv_lvl(priv_lvl), .dpc_ot(dpc_ot), .selected_proc(selected_proc),
    .ack(ack), .data_out(data_out), .viol(viol), .viol_addr(viol_addr),
    .viol_pc(viol_pc), .viol_proc(viol_proc), .viol_cnt(viol_cnt)
  );

  oc8051_shmem_resp #(.BASE_HI(8'hF0), .WAIT_CYCLES(0), .PROT_LIMIT(8'h80)) dut0 (
    .clk(clk), .rst(rst), .stb(stb0), .wr(wr), .addr(addr0), .data_in(data_in),
    .priv_lvl(priv_lvl), .dpc_ot(dpc_ot), .selected_proc(selected_proc),
    .ack(ack0), .data_out(data_out0), .viol(viol0), .viol_addr(w0_unused_vaddr),
    .viol_pc(w0_unused_vpc), .viol_proc(w0_unused_vproc), .viol_cnt(w0_unused_vcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image, last read value and violation log.
  logic [7:0]  m_mem [256];
  logic [7:0]  m_last_rd;
  logic [15:0] m_vaddr, m_vpc;
  logic        m_vproc;
  int          m_vcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last_rd = 8'h00;
    m_vaddr   = 16'h0000;
    m_vpc     = 16'h0000;
    m_vproc   = 1'b0;
    m_vcnt    = 0;
  endtask

  task automatic check_log(input string tag);
    check({tag, "_data_out"}, data_out, m_last_rd);
    check({tag, "_viol_addr"}, viol_addr, m_vaddr);
    check({tag, "_viol_pc"}, viol_pc, m_vpc);
    check({tag, "_viol_proc"}, viol_proc, m_vproc);
    check({tag, "_viol_cnt"}, viol_cnt, m_vcnt[7:0]);
  endtask

  task automatic do_txn(input bit w, input logic [15:0] a, input logic [7:0] d, input bit p,
                        input logic [15:0] pc, input bit pr, input bit hold);
    bit is_viol;
    int n;
    is_viol = PROT && (a[7:0] >= 8'h80) && !p;
    if (w) begin
      if (!is_viol) m_mem[a[7:0]] = d;
    end else begin
      m_last_rd = is_viol ? 8'h00 : m_mem[a[7:0]];
    end
    if (is_viol) begin
      m_vaddr = a;
      m_vpc   = pc;
      m_vproc = pr;
      m_vcnt  = (m_vcnt < 255) ? m_vcnt + 1 : 255;
    end
    @(negedge clk);
    stb = 1'b1; wr = w; addr = a; data_in = d; priv_lvl = p; dpc_ot = pc; selected_proc = pr;
    @(posedge clk); #1;
    if (!hold) stb = 1'b0;
    n = 0;
    while (!ack && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    stb = 1'b0;
    check("ack_latency", n, WAIT);
    check("viol_pulse", viol, is_viol);
    check_log("txn");
    @(posedge clk); #1;
    check("ack_width", ack, 1'b0);
    check("viol_width", viol, 1'b0);
  endtask

  task automatic do_miss();
    @(negedge clk);
    stb = 1'b1; wr = $urandom_range(0, 1); data_in = 8'($urandom);
    addr = {8'($urandom_range(0, 8'hEF)), 8'($urandom)};
    @(posedge clk); #1;
    stb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("miss_no_ack", ack, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  logic [15:0] z_addr [4];
  logic [7:0]  z_data [4];
  logic [7:0]  old_val;

  initial begin
    rst = 1'b1; stb = 1'b0; stb0 = 1'b0; wr = 1'b0; addr = 16'h0; addr0 = 16'h0;
    data_in = 8'h0; priv_lvl = 1'b0; dpc_ot = 16'h0; selected_proc = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 1'b0);
    check("rst_viol", viol, 1'b0);
    check("rst_ack0", ack0, 1'b0);
    check_log("rst");
    @(negedge clk); rst = 1'b0;

    // Give every location a known value with supervisor writes.
    for (int i = 0; i < 256; i++)
      do_txn(1'b1, {8'hF0, 8'(i)}, 8'($urandom), 1'b1, 16'($urandom), 1'($urandom), 1'b0);

    // Basic write/read at a user-accessible offset.
    do_txn(1'b1, 16'hF010, 8'h5A, 1'b0, 16'h0010, 1'b1, 1'b0);
    do_txn(1'b0, 16'hF010, 8'h00, 1'b0, 16'h0011, 1'b1, 1'b0);
    check("basic_rd", data_out, 8'h5A);

    // User write into the supervisor region, then supervisor readback.
    old_val = m_mem[8'h90];
    do_txn(1'b1, 16'hF090, 8'h33, 1'b0, 16'h0123, 1'b0, 1'b0);
`ifdef OC8051_SHMEM_PROT_EN
    check("prot_viol_cnt", viol_cnt, 8'h01);
    check("prot_viol_addr", viol_addr, 16'hF090);
`endif
    do_txn(1'b0, 16'hF090, 8'h00, 1'b1, 16'h0124, 1'b1, 1'b0);
    check("prot_rd", data_out, PROT ? old_val : 8'h33);

    // Misses leave the responder idle; stb held through WAIT is ignored.
    do_miss();
    do_txn(1'b0, 16'hF010, 8'h00, 1'b1, 16'h0200, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) do_miss();
      else do_txn(1'($urandom), {8'hF0, 8'($urandom)}, 8'($urandom), 1'($urandom),
                  16'($urandom), 1'($urandom), 1'($urandom));
    end

    // Zero-wait instance with stb held high: ack every other cycle.
    z_addr[0] = 16'hF001; z_addr[1] = 16'hF002; z_addr[2] = 16'hF001; z_addr[3] = 16'hF002;
    z_data[0] = 8'h11;    z_data[1] = 8'h22;    z_data[2] = 8'h11;    z_data[3] = 8'h22;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      stb0 = 1'b1; addr0 = z_addr[k / 2]; wr = (k < 4); priv_lvl = 1'b1;
      data_in = (k < 4) ? z_data[k / 2] : 8'h00;
      @(posedge clk); #1;
      check("w0_ack", ack0, (k % 2) == 0);
      check("w0_viol", viol0, 1'b0);
      if (k >= 4 && (k % 2) == 0) check("w0_data", data_out0, z_data[k / 2]);
    end
    @(negedge clk); stb0 = 1'b0;

    // Reset during WAIT of a write: no ack, no write, log cleared.
    old_val = m_mem[8'h20];
    @(negedge clk);
    stb = 1'b1; wr = 1'b1; addr = 16'hF020; data_in = ~old_val; priv_lvl = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; rst = 1'b1;
    #2;
    check("rstw_ack", ack, 1'b0);
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rstw_no_ack", ack, 1'b0);
    end
    check_log("rstw");
    do_txn(1'b0, 16'hF020, 8'h00, 1'b1, 16'h0300, 1'b0, 1'b0);
    check("rstw_rd", data_out, old_val);

    // Saturation of the violation counter.
    for (int i = 0; i < 256; i++)
      do_txn(1'b1, {8'hF0, 8'($urandom_range(8'h80, 8'hFF))}, 8'($urandom), 1'b0,
             16'($urandom), 1'($urandom), 1'b0);
`ifdef OC8051_SHMEM_PROT_EN
    check("viol_cnt_sat", viol_cnt, 8'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
